pipeline_if: RTL and testbench

PIPELINE_IF -- requirements
Module: pipeline_if

---
 rtl/pipeline_pkg.sv | 38 +++
 rtl/pipeline_if_pc_next_sel.sv | 56 +++++
 rtl/pipeline_if.sv | 154 +++++++++++++++
 tb/tb_pipeline_if.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings for the instruction fetch stage.
// PCSrc codes, vector defaults, IF FSM states and the IF/ID bundle.
package pipeline_pkg;

   localparam logic [2:0] PCSRC_SEQ   = 3'd0;
   localparam logic [2:0] PCSRC_BR    = 3'd1;
   localparam logic [2:0] PCSRC_J     = 3'd2;
   localparam logic [2:0] PCSRC_JR    = 3'd3;
   localparam logic [2:0] PCSRC_ILLOP = 3'd4;
   localparam logic [2:0] PCSRC_XADR  = 3'd5;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [31:0] ILLOP_DEF    = 32'h8000_0004;
   localparam logic [31:0] XADR_DEF     = 32'h8000_0008;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } if_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } if_id_t;

   // J/JAL target keeps the region bits of the sequential successor.
   function automatic logic [31:0] jump_target(
      input logic [31:0] pc,
      input logic [25:0] jt
   );
      logic [31:0] w_pc4;
      w_pc4 = pc + 32'd4;
      return {w_pc4[31:28], jt, 2'b00};
   endfunction

endpackage

// File: rtl/pipeline_if_pc_next_sel.sv
// pc_next_sel: decides whether ID redirects fetch, and where to.
// Purely combinational; PCSrc 6/7 fall through as sequential.
module pc_next_sel
   import pipeline_pkg::*;
#(
   parameter logic [31:0] ILLOP_ADDR = ILLOP_DEF,
   parameter logic [31:0] XADR_ADDR  = XADR_DEF
) (
   input  logic [2:0]  i_pcsrc,
   input  logic        i_flush,
   input  logic        i_id_valid,
   input  logic        i_stall,
   input  logic [31:0] i_conba,
   input  logic [25:0] i_jt,
   input  logic [31:0] i_dba,
   input  logic [31:0] i_id_pc,
   output logic        o_redirect,
   output logic [31:0] o_target
);

   // Select target; a stalled or empty ID slot never redirects.
   always_comb begin
      o_redirect = 1'b0;
      o_target   = 32'd0;
      case (i_pcsrc)
         PCSRC_BR: begin
            o_redirect = i_flush;
            o_target   = i_conba;
         end
         PCSRC_J: begin
            o_redirect = 1'b1;
            o_target   = jump_target(i_id_pc, i_jt);
         end
         PCSRC_JR: begin
            o_redirect = 1'b1;
            o_target   = i_dba;
         end
         PCSRC_ILLOP: begin
            o_redirect = 1'b1;
            o_target   = ILLOP_ADDR;
         end
         PCSRC_XADR: begin
            o_redirect = 1'b1;
            o_target   = XADR_ADDR;
         end
         default: begin
            o_redirect = 1'b0;
            o_target   = 32'd0;
         end
      endcase
      if (!i_id_valid || i_stall) begin
         o_redirect = 1'b0;
      end
   end

endmodule

// File: rtl/pipeline_if.sv
// pipeline_if: IF stage with IF/ID register, skid slot and drain of
// wrong-path fetches. Optional fetch counter under IF_PERF_CNT_EN.
module pipeline_if
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [31:0] ILLOP_ADDR = ILLOP_DEF,
   parameter logic [31:0] XADR_ADDR  = XADR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  PCSrc,
   input  logic        IFID_flush,
   input  logic [31:0] ConBA,
   input  logic [25:0] JT,
   input  logic [31:0] DatabusA,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ID_PC,
   output logic [31:0] ID_instruction,
   output logic        ID_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt
`endif
);

   if_state_e   r_state;
   logic [31:0] r_pc;
   logic [31:0] r_tgt;
   logic        r_req;
   if_id_t      r_ifid;
   if_id_t      r_skid;

   logic        w_redir;
   logic [31:0] w_target;
   logic [31:0] w_pc4;
   if_id_t      w_bubble;
   if_id_t      w_fetched;

   pc_next_sel #(
      .ILLOP_ADDR (ILLOP_ADDR),
      .XADR_ADDR  (XADR_ADDR)
   ) u_sel (
      .i_pcsrc    (PCSrc),
      .i_flush    (IFID_flush),
      .i_id_valid (r_ifid.valid),
      .i_stall    (stall),
      .i_conba    (ConBA),
      .i_jt       (JT),
      .i_dba      (DatabusA),
      .i_id_pc    (r_ifid.pc),
      .o_redirect (w_redir),
      .o_target   (w_target)
   );

   assign w_pc4     = r_pc + 32'd4;
   assign w_bubble  = '{pc: r_ifid.pc, instr: 32'd0, valid: 1'b0};
   assign w_fetched = '{pc: r_pc, instr: imem_rdata, valid: 1'b1};

   assign imem_req       = r_req;
   assign imem_addr      = r_pc;
   assign ID_PC          = r_ifid.pc;
   assign ID_instruction = r_ifid.instr;
   assign ID_valid       = r_ifid.valid;

   // Fetch FSM: owns PC, IF/ID, skid slot and the pending redirect.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_FETCH;
         r_pc    <= RESET_PC;
         r_tgt   <= 32'd0;
         r_req   <= 1'b1;
         r_ifid  <= '{pc: RESET_PC, instr: 32'd0, valid: 1'b0};
         r_skid  <= '0;
      end else begin
         unique case (r_state)
            S_FETCH: begin
               if (stall) begin
                  if (imem_ready) begin
                     r_skid  <= w_fetched;
                     r_pc    <= w_pc4;
                     r_req   <= 1'b0;
                     r_state <= S_HOLD;
                  end
               end else if (w_redir) begin
                  r_ifid <= w_bubble;
                  if (imem_ready) begin
                     r_pc <= w_target;
                  end else begin
                     r_tgt   <= w_target;
                     r_state <= S_DRAIN;
                  end
               end else if (imem_ready) begin
                  r_ifid <= w_fetched;
                  r_pc   <= w_pc4;
               end else begin
                  r_ifid <= w_bubble;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  r_ifid       <= w_redir ? w_bubble : r_skid;
                  r_skid.valid <= 1'b0;
                  if (w_redir) begin
                     r_pc <= w_target;
                  end
                  r_req   <= 1'b1;
                  r_state <= S_FETCH;
               end
            end
            S_DRAIN: begin
               if (!stall) begin
                  r_ifid <= w_bubble;
               end
               if (w_redir) begin
                  r_tgt <= w_target;
               end
               if (imem_ready) begin
                  r_pc    <= w_redir ? w_target : r_tgt;
                  r_state <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   logic        w_ld_valid;
   logic [31:0] r_fetch_cnt;

   assign w_ld_valid =
      !stall && !w_redir &&
      (((r_state == S_FETCH) && imem_ready) ||
       ((r_state == S_HOLD) && r_skid.valid));
   assign fetch_cnt = r_fetch_cnt;

   // Count real instructions entering IF/ID; wraps naturally.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_fetch_cnt <= 32'd0;
      end else if (w_ld_valid) begin
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_if.sv
// tb_pipeline_if: directed vector table plus randomized run against
// an instruction-stream reference model of the fetch stage.
module tb_pipeline_if;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  PCSrc;
   logic        IFID_flush;
   logic [31:0] ConBA;
   logic [25:0] JT;
   logic [31:0] DatabusA;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] ID_PC;
   logic [31:0] ID_instruction;
   logic        ID_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt;
`endif

   pipeline_if dut (
      .clk            (clk),
      .reset          (reset),
      .PCSrc          (PCSrc),
      .IFID_flush     (IFID_flush),
      .ConBA          (ConBA),
      .JT             (JT),
      .DatabusA       (DatabusA),
      .stall          (stall),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .ID_PC          (ID_PC),
      .ID_instruction (ID_instruction),
      .ID_valid       (ID_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt      (fetch_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [2:0]  src;
      logic        fl;
      logic [31:0] cba;
      logic [25:0] jt;
      logic [31:0] dba;
      logic        st;
      logic        rdy;
      logic        chk;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic [31:0] ins;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic row(
      input logic rs, input logic [2:0] sr, input logic f,
      input logic [31:0] cb, input logic [25:0] j, input logic [31:0] db,
      input logic s, input logic r, input logic c, input logic q,
      input logic [31:0] a, input logic v, input logic [31:0] p,
      input logic [31:0] n
   );
      vec_t t;
      t.rst = rs; t.src = sr; t.fl = f; t.cba = cb; t.jt = j;
      t.dba = db; t.st = s; t.rdy = r; t.chk = c; t.req = q;
      t.addr = a; t.vld = v; t.pc = p; t.ins = n;
      tbl.push_back(t);
   endtask

   // memory content: word at byte address a is a>>2
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a >> 2;
   endfunction

   logic [31:0] exp_next, cur_pc, prev_addr, tgt;
   logic [31:0] sv_pc, sv_ins;
   logic        sv_vld;
   logic        p_st, p_rd, p_wait, p_cap, drain, redir;
   int          n_ins;

   initial begin
      reset = 1'b0; PCSrc = 3'd0; IFID_flush = 1'b0; ConBA = 32'd0;
      JT = 26'd0; DatabusA = 32'd0; stall = 1'b0;
      imem_ready = 1'b0; imem_rdata = 32'd0;

      //   rst src fl cba           jt         dba           st rdy chk req addr          vld pc            ins
      row(0, 0, 0, 32'h0,         26'h0,     32'h0,        0, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h80000000, 0, 32'h80000000, 32'h0);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h80000004, 1, 32'h80000000, 32'h20000000);
      row(1, 1, 1, 32'h80000040, 26'h0,     32'h0,        0, 1,  1, 1, 32'h80000008, 1, 32'h80000004, 32'h20000001);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h80000040, 0, 32'h80000004, 32'h0);
      row(1, 1, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h80000044, 1, 32'h80000040, 32'h20000010);
      row(1, 3, 0, 32'h0,         26'h0,     32'h00400010, 0, 0,  1, 1, 32'h80000048, 1, 32'h80000044, 32'h20000011);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 0,  1, 1, 32'h80000048, 0, 32'h80000044, 32'h0);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 0,  1, 1, 32'h80000048, 0, 32'h80000044, 32'h0);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h80000048, 0, 32'h80000044, 32'h0);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h00400010, 0, 32'h80000044, 32'h0);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        1, 1,  1, 1, 32'h00400014, 1, 32'h00400010, 32'h00100004);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        1, 0,  1, 0, 32'h00400018, 1, 32'h00400010, 32'h00100004);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 0,  1, 0, 32'h00400018, 1, 32'h00400010, 32'h00100004);
      row(1, 5, 0, 32'h0,         26'h0,     32'h0,        1, 1,  1, 1, 32'h00400018, 1, 32'h00400014, 32'h00100005);
      row(1, 5, 0, 32'h0,         26'h0,     32'h0,        1, 0,  1, 0, 32'h0040001C, 1, 32'h00400014, 32'h00100005);
      row(1, 5, 0, 32'h0,         26'h0,     32'h0,        0, 0,  1, 0, 32'h0040001C, 1, 32'h00400014, 32'h00100005);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h80000008, 0, 32'h00400014, 32'h0);
      row(0, 0, 0, 32'h0,         26'h0,     32'h0,        0, 0,  1, 1, 32'h8000000C, 1, 32'h80000008, 32'h20000002);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h80000000, 0, 32'h80000000, 32'h0);
      row(1, 2, 0, 32'h0,         26'h100,   32'h0,        0, 1,  1, 1, 32'h80000004, 1, 32'h80000000, 32'h20000000);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h80000400, 0, 32'h80000000, 32'h0);
      row(1, 4, 0, 32'h0,         26'h0,     32'h0,        0, 0,  1, 1, 32'h80000404, 1, 32'h80000400, 32'h20000100);
      row(1, 7, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h80000404, 0, 32'h80000400, 32'h0);
      row(1, 7, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h80000004, 0, 32'h80000400, 32'h0);
      row(1, 7, 0, 32'h0,         26'h0,     32'h0,        0, 1,  1, 1, 32'h80000008, 1, 32'h80000004, 32'h20000001);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 0,  1, 1, 32'h8000000C, 1, 32'h80000008, 32'h20000002);
      row(1, 0, 0, 32'h0,         26'h0,     32'h0,        0, 0,  1, 1, 32'h8000000C, 0, 32'h80000008, 32'h0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         if (tbl[i].chk) begin
            cmp($sformatf("v%0d req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
            cmp($sformatf("v%0d addr", i), imem_addr, tbl[i].addr);
            cmp($sformatf("v%0d valid", i), {31'd0, ID_valid}, {31'd0, tbl[i].vld});
            cmp($sformatf("v%0d pc", i), ID_PC, tbl[i].pc);
            cmp($sformatf("v%0d instr", i), ID_instruction, tbl[i].ins);
         end
         reset = tbl[i].rst; PCSrc = tbl[i].src; IFID_flush = tbl[i].fl;
         ConBA = tbl[i].cba; JT = tbl[i].jt; DatabusA = tbl[i].dba;
         stall = tbl[i].st; imem_ready = tbl[i].rdy;
         imem_rdata = mem(imem_addr);
      end

      // randomized run: model tracks the expected program-order stream
      @(negedge clk);
      reset = 1'b0; stall = 1'b0; imem_ready = 1'b0; PCSrc = 3'd0;
      exp_next = 32'h8000_0000; cur_pc = 32'h8000_0000;
      prev_addr = 32'd0; sv_pc = 32'd0; sv_ins = 32'd0; sv_vld = 1'b0;
      p_st = 1'b0; p_rd = 1'b0; p_wait = 1'b0; p_cap = 1'b0;
      drain = 1'b0; n_ins = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (p_wait) begin
            cmp("rnd req held", {31'd0, imem_req}, 32'd1);
            cmp("rnd addr held", imem_addr, prev_addr);
         end
         if (p_cap) begin
            cmp("rnd req off in hold", {31'd0, imem_req}, 32'd0);
         end
         if (p_st) begin
            cmp("rnd frozen pc", ID_PC, sv_pc);
            cmp("rnd frozen instr", ID_instruction, sv_ins);
            cmp("rnd frozen valid", {31'd0, ID_valid}, {31'd0, sv_vld});
         end else if (p_rd) begin
            cmp("rnd bubble", {31'd0, ID_valid}, 32'd0);
         end else if (ID_valid) begin
            cmp("rnd stream pc", ID_PC, exp_next);
            cmp("rnd stream instr", ID_instruction, mem(exp_next));
            cur_pc   = exp_next;
            exp_next = exp_next + 32'd4;
            n_ins++;
         end
         sv_pc = ID_PC; sv_ins = ID_instruction; sv_vld = ID_valid;

         reset = 1'b1;
         stall = ($urandom_range(99) < 20);
         imem_ready = imem_req && ($urandom_range(99) < 65);
         PCSrc = ($urandom_range(99) < 70) ? 3'd0 : 3'($urandom_range(7));
         IFID_flush = $urandom_range(1) == 1;
         ConBA = $urandom & 32'hFFFF_FFFC;
         DatabusA = $urandom & 32'hFFFF_FFFC;
         JT = 26'($urandom);
         imem_rdata = mem(imem_addr);

         redir = 1'b0;
         tgt = 32'd0;
         if (ID_valid && !stall) begin
            if (PCSrc == 3'd1 && IFID_flush) begin
               redir = 1'b1; tgt = ConBA;
            end else if (PCSrc == 3'd2) begin
               redir = 1'b1;
               tgt = ((cur_pc + 32'd4) & 32'hF000_0000) | ({6'd0, JT} << 2);
            end else if (PCSrc == 3'd3) begin
               redir = 1'b1; tgt = DatabusA;
            end else if (PCSrc == 3'd4) begin
               redir = 1'b1; tgt = 32'h8000_0004;
            end else if (PCSrc == 3'd5) begin
               redir = 1'b1; tgt = 32'h8000_0008;
            end
         end
         if (redir) exp_next = tgt;

         p_wait = imem_req && !imem_ready;
         p_cap  = imem_req && imem_ready && stall && !drain;
         if (drain && imem_ready) drain = 1'b0;
         if (redir && !imem_ready) drain = 1'b1;
         p_st = stall; p_rd = redir; prev_addr = imem_addr;
      end
      cmp("rnd progress", {31'd0, n_ins >= 300}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
